// File: rtl/mnist_pkg.sv
// Shared MNIST geometry and loader state type, imported by the image loader
// and the conv layers downstream of it.
package mnist_pkg;
  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int PIX_W  = 8;
  localparam int IMG_AW = 10;

  // conv1: valid 3x3 convolution, no padding, stride 1
  localparam int C1_K     = 3;
  localparam int C1_OUT_W = IMG_W - C1_K + 1;
  localparam int C1_OUT_H = IMG_H - C1_K + 1;
  localparam int C1_NCH   = 4;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_HOLD = 1'b1
  } ld_state_t;
endpackage

// File: rtl/img_ram.sv
// Simple dual-port frame RAM: one write port and one registered read port.
// A read and a write to the same address in one cycle return the old data.
module img_ram #(
  parameter int DW = 8,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/img_loader.sv
// Single-buffered input frame store for conv1: loads one raster-order image,
// hands it to the consumer via upstream_busy, and serves its reads.
//
// state   | meaning
// LOAD    | accepting pixels into the frame RAM
// HOLD    | frame complete, owned by the consumer until consumer_done
module img_loader #(
  parameter int IMG_W = mnist_pkg::IMG_W,
  parameter int IMG_H = mnist_pkg::IMG_H,
  parameter int DW    = mnist_pkg::PIX_W,
  parameter int AW    = mnist_pkg::IMG_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          s_ready,
  input  logic [AW-1:0] raddr,
  input  logic          ren,
  output logic [DW-1:0] rdata,
  output logic          upstream_busy,
  input  logic          consumer_done,
  output logic          frame_err
);
  import mnist_pkg::*;

  localparam int            NPIX_L   = IMG_W * IMG_H;
  localparam logic [AW-1:0] LAST_PIX = AW'(NPIX_L - 1);

  ld_state_t     state;
  logic [AW-1:0] wptr;
  logic          accept;
  logic          in_range_q;
  logic [DW-1:0] ram_rdata;

  assign s_ready = (state == ST_LOAD) && !rst;
  assign accept  = s_valid && s_ready;

  img_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (wptr),
    .wdata (s_data),
    .re    (ren && !rst),
    .raddr (raddr),
    .rdata (ram_rdata)
  );

  // Out-of-range reads return zero; the flag tracks the read it belongs to,
  // so rdata holds along with the RAM output when ren is low.
  assign rdata = in_range_q ? ram_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_LOAD;
      wptr          <= '0;
      upstream_busy <= 1'b0;
      frame_err     <= 1'b0;
      in_range_q    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (ren) in_range_q <= (raddr <= LAST_PIX);
      case (state)
        ST_LOAD: begin
          if (accept) begin
            if (wptr == LAST_PIX) begin
              wptr          <= '0;
              state         <= ST_HOLD;
              upstream_busy <= 1'b1;
              frame_err     <= !s_last;
            end else if (s_last) begin
              wptr      <= '0;
              frame_err <= 1'b1;
            end else begin
              wptr <= wptr + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (consumer_done) begin
            state         <= ST_LOAD;
            upstream_busy <= 1'b0;
            wptr          <= '0;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end
endmodule
